if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Fetch-to-decode pipeline stage. Sits directly downstream of the PC unit and the instruction memory/cache.
- Captures the fetched instruction and its PC+2 into the IF/ID register, and inserts NOP bubbles on flush or memory wait.
- Holds one early-returned instruction in a skid buffer while decode is stalled.
- Drives pause_PC and halt back to the PC unit.

Parameters:
- NOP_INSTR, 16'h0800, encoding injected as a bubble (opcode 00001).
- HALT_OPC, 5'b00000, opcode bits [15:11] that identify HALT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- instr_in  input  16  instruction data from imem for instr_addr
- imem_done  input  1  imem data valid this cycle
- imem_stall  input  1  imem busy (cache miss in progress)
- pc2_in  input  16  PC+2 from PC unit (PC_2)
- flush  input  1  branch/jump taken in later stage (same as pc_sel)
- stall_id  input  1  hazard unit holds ID stage
- instr_out  output  16  IF/ID instruction to decode
- pc2_out  output  16  IF/ID PC+2 to decode
- valid_out  output  1  instr_out is a real instruction
- pause_PC  output  1  to PC unit: hold PC
- halt  output  1  to PC unit: stop increment (HALT fetched)

Behaviour:
- Reset (rst=0, async):
  - instr_out=NOP_INSTR, pc2_out=0, valid_out=0, halt=0.
  - Skid buffer empty; FSM=RUN.
- FSM states: RUN, WAIT_MEM, HALTED.
  - RUN -> WAIT_MEM when imem_stall=1 and imem_done=0.
  - WAIT_MEM -> RUN on imem_done=1.
  - RUN/WAIT_MEM -> HALTED when a valid instruction with [15:11]==HALT_OPC is loaded into IF/ID.
  - HALTED -> RUN only on flush.
  - flush from any state -> RUN.
- Source selection: the IF/ID load source is the skid buffer if full, else instr_in/pc2_in.
- Load condition: stall_id=0 and (skid full or imem_done=1), in RUN/WAIT_MEM. Loaded source gets valid_out=1 on the next edge.
- Bubble: when stall_id=0 and nothing is loadable (imem busy or no done), IF/ID gets NOP_INSTR with valid_out=0. pc2_out holds its value.
- Stall: when stall_id=1, IF/ID holds all outputs unchanged.
  - If imem_done=1 while stall_id=1 and the skid is empty, capture instr_in/pc2_in into the skid; skid becomes full.
  - Skid drains on the first cycle with stall_id=0.
- Flush has priority over everything:
  - instr_out<=NOP_INSTR, valid_out<=0, skid emptied, halt<=0, FSM<=RUN.
  - The current imem_done data is discarded.
- halt=1 while in HALTED (registered, set the edge HALT enters IF/ID). In HALTED, IF/ID holds the HALT instruction with valid_out=1.
- pause_PC (combinational) = stall_id | skid_full | (imem_stall & ~imem_done) | HALTED, forced to 0 when flush=1 so the jump target loads.
- Latency: instr_in with imem_done in cycle N appears on instr_out at edge N+1 if stall_id=0. With the skid used, it appears 1 cycle after stall_id drops.
- Simultaneous events:
  - flush with stall_id: flush wins.
  - imem_done with skid full and stall_id=1: impossible by contract, since pause_PC holds fetch. Treat as an assertion error in the bench; RTL keeps the skid contents.
- Reset mid-miss: returns to RUN with an empty skid; a late imem_done after reset is accepted as a normal fetch.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined:
  - Adds output bubble_cnt[15:0], incremented on every edge that loads a NOP bubble (valid_out becomes 0 for non-flush reasons).
  - Adds output flush_cnt[15:0], incremented on each flush.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: no counters, no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset, then imem_done=1 with instr_in=16'h4123 and pc2_in=16'h0002 each cycle:
  - instr_out=16'h4123, valid_out=1, pc2_out=16'h0002 one cycle later.
  - pause_PC=0.
- imem_stall=1 for 3 cycles, then done with 16'h5A5A:
  - 3 bubbles (instr_out=16'h0800, valid_out=0) with pause_PC=1.
  - Then 16'h5A5A valid.
- stall_id=1 for 2 cycles while imem_done delivers 16'h1111:
  - IF/ID holds its previous value; skid captures 16'h1111; pause_PC=1.
  - 16'h1111 appears 1 cycle after stall_id drops.
- Fetch 16'h0000 (HALT):
  - halt=1 and pause_PC=1 next cycle; IF/ID holds 16'h0000 indefinitely.
  - flush then clears halt and loads NOP with valid_out=0.
- flush asserted together with stall_id=1 and a full skid:
  - Next edge: instr_out=16'h0800, valid_out=0, skid empty, pause_PC=0 during the flush cycle.
- With IF_ID_PERF_EN defined, run scenarios 2 and 5:
  - bubble_cnt=3, flush_cnt=1.
  - Assert rst=0 mid-run: both counters read 0 immediately.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, bubble insertion and HALT detection.
// Optional performance counters (bubble_cnt, flush_cnt) are enabled with `define IF_ID_PERF_EN.
module if_id_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic        imem_done,
    input  logic        imem_stall,
    input  logic [15:0] pc2_in,
    input  logic        flush,
    input  logic        stall_id,
    output logic [15:0] instr_out,
    output logic [15:0] pc2_out,
    output logic        valid_out,
    output logic        pause_PC,
`ifdef IF_ID_PERF_EN
    output logic [15:0] bubble_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        halt
);

    typedef enum logic [1:0] {
        StRun,
        StWaitMem,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic        skid_full_q, skid_full_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;

    logic [15:0] src_instr;
    logic [15:0] src_pc2;
    logic        src_avail;

    // A full skid always takes precedence over the live imem data.
    assign src_instr = skid_full_q ? skid_instr_q : instr_in;
    assign src_pc2   = skid_full_q ? skid_pc2_q : pc2_in;
    assign src_avail = skid_full_q | imem_done;

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc2_d        = pc2_q;
        valid_d      = valid_q;
        halt_d       = halt_q;
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;

        if (flush) begin
            state_d     = StRun;
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
            halt_d      = 1'b0;
            skid_full_d = 1'b0;
        end else if (state_q != StHalted) begin
            if (stall_id) begin
                // Park an early-returned fetch; a full skid is never overwritten.
                if (imem_done && !skid_full_q) begin
                    skid_full_d  = 1'b1;
                    skid_instr_d = instr_in;
                    skid_pc2_d   = pc2_in;
                end
            end else if (src_avail) begin
                instr_d     = src_instr;
                pc2_d       = src_pc2;
                valid_d     = 1'b1;
                skid_full_d = 1'b0;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end

            if (!stall_id && src_avail && (src_instr[15:11] == HALT_OPC)) begin
                state_d = StHalted;
                halt_d  = 1'b1;
            end else if (state_q == StRun && imem_stall && !imem_done) begin
                state_d = StWaitMem;
            end else if (state_q == StWaitMem && imem_done) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StRun;
            instr_q      <= NOP_INSTR;
            pc2_q        <= 16'h0000;
            valid_q      <= 1'b0;
            halt_q       <= 1'b0;
            skid_full_q  <= 1'b0;
            skid_instr_q <= 16'h0000;
            skid_pc2_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc2_q        <= pc2_d;
            valid_q      <= valid_d;
            halt_q       <= halt_d;
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc2_q   <= skid_pc2_d;
        end
    end

    // Released during flush so the PC unit can load the jump target.
    assign pause_PC = ~flush & (stall_id | skid_full_q | (imem_stall & ~imem_done)
                                | (state_q == StHalted));

    assign instr_out = instr_q;
    assign pc2_out   = pc2_q;
    assign valid_out = valid_q;
    assign halt      = halt_q;

`ifdef IF_ID_PERF_EN
    logic        perf_bubble;
    logic [15:0] bubble_cnt_q;
    logic [15:0] flush_cnt_q;

    assign perf_bubble = ~flush & (state_q != StHalted) & ~stall_id & ~src_avail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= 16'h0000;
            flush_cnt_q  <= 16'h0000;
        end else begin
            if (perf_bubble && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'h0001;
            end
            if (flush && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'h0001;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: expected IF/ID contents are queued as each step is driven
// and checked one edge later; counters are checked when IF_ID_PERF_EN is defined.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic        imem_done;
    logic        imem_stall;
    logic [15:0] pc2_in;
    logic        flush;
    logic        stall_id;
    logic [15:0] instr_out;
    logic [15:0] pc2_out;
    logic        valid_out;
    logic        pause_PC;
    logic        halt;
`ifdef IF_ID_PERF_EN
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;
`endif

    if_id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .imem_done  (imem_done),
        .imem_stall (imem_stall),
        .pc2_in     (pc2_in),
        .flush      (flush),
        .stall_id   (stall_id),
        .instr_out  (instr_out),
        .pc2_out    (pc2_out),
        .valid_out  (valid_out),
        .pause_PC   (pause_PC),
`ifdef IF_ID_PERF_EN
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .halt       (halt)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   exp_bub      = 0;
    int   exp_fl       = 0;
    logic cur_halt     = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] want);
        tests_run++;
        assert (got === want) else begin
            tests_failed++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic want);
        tests_run++;
        assert (got === want) else begin
            tests_failed++;
            $error("FAIL %s got %b want %b", tag, got, want);
        end
    endtask

    // Called just after a falling edge: drive, check pause_PC, clock once, check IF/ID.
    task automatic step(input string tag, input logic [15:0] i_instr, input logic [15:0] i_pc2,
                        input logic i_done, input logic i_imst, input logic i_flush,
                        input logic i_stall, input logic e_pause, input logic [15:0] e_instr,
                        input logic [15:0] e_pc2, input logic e_valid, input logic e_halt);
        exp_t e;
        instr_in   = i_instr;
        pc2_in     = i_pc2;
        imem_done  = i_done;
        imem_stall = i_imst;
        flush      = i_flush;
        stall_id   = i_stall;
        #1;
        check1({tag, ".pause"}, pause_PC, e_pause);
        if (i_flush) exp_fl++;
        else if (!i_stall && !cur_halt && !e_valid) exp_bub++;
        e.instr = e_instr;
        e.pc2   = e_pc2;
        e.valid = e_valid;
        e.halt  = e_halt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check16({tag, ".instr"}, instr_out, e.instr);
        check16({tag, ".pc2"}, pc2_out, e.pc2);
        check1({tag, ".valid"}, valid_out, e.valid);
        check1({tag, ".halt"}, halt, e.halt);
`ifdef IF_ID_PERF_EN
        check16({tag, ".bubble_cnt"}, bubble_cnt, 16'(exp_bub));
        check16({tag, ".flush_cnt"}, flush_cnt, 16'(exp_fl));
`endif
        cur_halt = e_halt;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        instr_in   = 16'h0000;
        pc2_in     = 16'h0000;
        imem_done  = 1'b0;
        imem_stall = 1'b0;
        flush      = 1'b0;
        stall_id   = 1'b0;
        @(negedge clk);
        check16("rst.instr", instr_out, 16'h0800);
        check16("rst.pc2", pc2_out, 16'h0000);
        check1("rst.valid", valid_out, 1'b0);
        check1("rst.halt", halt, 1'b0);
        check1("rst.pause", pause_PC, 1'b0);
        rst = 1'b1;

        // Straight-line fetch
        step("fetch0", 16'h4123, 16'h0002, 1, 0, 0, 0, 0, 16'h4123, 16'h0002, 1, 0);
        step("fetch1", 16'h4123, 16'h0002, 1, 0, 0, 0, 0, 16'h4123, 16'h0002, 1, 0);

        // Memory miss: three bubbles, pc2 held
        step("miss0", 16'h0000, 16'h0004, 0, 1, 0, 0, 1, 16'h0800, 16'h0002, 0, 0);
        step("miss1", 16'h0000, 16'h0004, 0, 1, 0, 0, 1, 16'h0800, 16'h0002, 0, 0);
        step("miss2", 16'h0000, 16'h0004, 0, 1, 0, 0, 1, 16'h0800, 16'h0002, 0, 0);
        step("missdone", 16'h5A5A, 16'h0004, 1, 0, 0, 0, 0, 16'h5A5A, 16'h0004, 1, 0);

        // Decode stall with early return into the skid
        step("stall0", 16'h1111, 16'h0006, 1, 0, 0, 1, 1, 16'h5A5A, 16'h0004, 1, 0);
        step("stall1", 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'h5A5A, 16'h0004, 1, 0);
        step("drain", 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h1111, 16'h0006, 1, 0);
        step("after", 16'h2222, 16'h0008, 1, 0, 0, 0, 0, 16'h2222, 16'h0008, 1, 0);

        // HALT fetch, hold, then flush out
        step("halt0", 16'h0000, 16'h000A, 1, 0, 0, 0, 0, 16'h0000, 16'h000A, 1, 1);
        step("halt1", 16'h0000, 16'h000A, 0, 0, 0, 0, 1, 16'h0000, 16'h000A, 1, 1);
        step("halt2", 16'h3333, 16'h000C, 1, 0, 0, 0, 1, 16'h0000, 16'h000A, 1, 1);
        step("hflush", 16'h0000, 16'h000C, 0, 0, 1, 0, 0, 16'h0800, 16'h000A, 0, 0);

        // Flush with stall and a full skid: skid contents must be dropped
        step("skfill", 16'h4444, 16'h000C, 1, 0, 0, 1, 1, 16'h0800, 16'h000A, 0, 0);
        step("skflush", 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'h0800, 16'h000A, 0, 0);
        step("postfl", 16'h5555, 16'h000E, 1, 0, 0, 0, 0, 16'h5555, 16'h000E, 1, 0);

        // Reset in the middle of a miss, then a late done is a normal fetch
        step("mmiss", 16'h0000, 16'h0010, 0, 1, 0, 0, 1, 16'h0800, 16'h000E, 0, 0);
        rst = 1'b0;
        #1;
        check16("mrst.instr", instr_out, 16'h0800);
        check16("mrst.pc2", pc2_out, 16'h0000);
        check1("mrst.valid", valid_out, 1'b0);
        check1("mrst.halt", halt, 1'b0);
`ifdef IF_ID_PERF_EN
        check16("mrst.bubble_cnt", bubble_cnt, 16'h0000);
        check16("mrst.flush_cnt", flush_cnt, 16'h0000);
`endif
        exp_bub  = 0;
        exp_fl   = 0;
        cur_halt = 1'b0;
        rst      = 1'b1;
        step("late", 16'h6666, 16'h0010, 1, 0, 0, 0, 0, 16'h6666, 16'h0010, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
